// File: rtl/pes_pipedivider.sv
// Iterative IEEE-754 single-precision divider F = A / B, restoring division, one quotient bit per cycle.
// Define PES_PIPEDIVIDER_ROUND_EN for round-to-nearest-even; default build truncates toward zero.
module pes_pipedivider #(
  parameter int QBITS = 26,
  parameter int BIAS  = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] F,
  output logic        div_by_zero
);
  // state | meaning
  // IDLE  | waiting for an operand pair
  // DIV   | one restoring quotient step per cycle
  // NORM  | normalise quotient, form F (or take the special result)
  // HOLD  | result presented until out_ready
  typedef enum logic [1:0] {IDLE, DIV, NORM, HOLD} state_t;

  localparam int CW = $clog2(QBITS);

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [24:0]       rem;
  logic [23:0]       dvs;
  logic [QBITS-1:0]  q;
  logic              sgn;
  logic signed [9:0] exp_base;
  logic              special;
  logic [31:0]       spec_f;
  logic              spec_dbz;

  logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic        in_sgn, in_special, in_dbz;
  logic [31:0] in_f;

  // Subnormals have exponent 0 and are flushed to zero by the zero test.
  assign a_zero = (A[30:23] == 8'h00);
  assign b_zero = (B[30:23] == 8'h00);
  assign a_inf  = (A[30:23] == 8'hFF) && (A[22:0] == 23'h0);
  assign b_inf  = (B[30:23] == 8'hFF) && (B[22:0] == 23'h0);
  assign a_nan  = (A[30:23] == 8'hFF) && (A[22:0] != 23'h0);
  assign b_nan  = (B[30:23] == 8'hFF) && (B[22:0] != 23'h0);
  assign in_sgn = A[31] ^ B[31];

  always_comb begin
    in_special = 1'b1;
    in_dbz     = 1'b0;
    in_f       = {in_sgn, 31'h0};
    if (a_nan || b_nan)                          in_f = 32'h7FC00000;
    else if ((a_zero && b_zero) || (a_inf && b_inf)) in_f = 32'h7FC00000;
    else if (a_inf)                              in_f = {in_sgn, 8'hFF, 23'h0};
    else if (b_inf)                              in_f = {in_sgn, 31'h0};
    else if (a_zero)                             in_f = {in_sgn, 31'h0};
    else if (b_zero) begin
      in_f   = {in_sgn, 8'hFF, 23'h0};
      in_dbz = 1'b1;
    end
    else in_special = 1'b0;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = in_special ? NORM : DIV;
      DIV:  if (cnt == CW'(QBITS-1)) state_nx = NORM;
      NORM: state_nx = HOLD;
      HOLD: if (out_valid && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);

  logic        ge;
  logic [24:0] rem_sub;
  assign ge      = (rem >= {1'b0, dvs});
  assign rem_sub = ge ? (rem - {1'b0, dvs}) : rem;

  logic signed [9:0] e_n;
  logic [22:0]       frac;
  logic [31:0]       norm_f;
`ifdef PES_PIPEDIVIDER_ROUND_EN
  logic [QBITS-1:0] qn;
  logic             guard, sticky, carry;
  logic [22:0]      frac_t;
`endif

  always_comb begin
    e_n  = exp_base - (q[QBITS-1] ? 10'sd0 : 10'sd1);
    frac = q[QBITS-1] ? q[QBITS-2 -: 23] : q[QBITS-3 -: 23];
`ifdef PES_PIPEDIVIDER_ROUND_EN
    qn     = q[QBITS-1] ? q : {q[QBITS-2:0], 1'b0};
    guard  = qn[QBITS-25];
    sticky = (|qn[QBITS-26:0]) || (|rem);
    frac_t = frac;
    {carry, frac} = {1'b0, frac_t} + {23'h0, guard && (sticky || frac_t[0])};
    if (carry) e_n = e_n + 10'sd1;
`endif
    if (e_n >= 10'sd255)    norm_f = {sgn, 8'hFF, 23'h0};
    else if (e_n <= 10'sd0) norm_f = {sgn, 31'h0};
    else                    norm_f = {sgn, e_n[7:0], frac};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      dvs         <= '0;
      q           <= '0;
      sgn         <= 1'b0;
      exp_base    <= '0;
      special     <= 1'b0;
      spec_f      <= '0;
      spec_dbz    <= 1'b0;
      out_valid   <= 1'b0;
      F           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid) begin
          sgn      <= in_sgn;
          exp_base <= $signed({2'b00, A[30:23]}) - $signed({2'b00, B[30:23]}) + 10'(BIAS);
          special  <= in_special;
          spec_f   <= in_f;
          spec_dbz <= in_dbz;
          rem      <= {2'b01, A[22:0]};
          dvs      <= {1'b1, B[22:0]};
          q        <= '0;
          cnt      <= '0;
        end
        DIV: begin
          rem <= {rem_sub[23:0], 1'b0};
          q   <= {q[QBITS-2:0], ge};
          cnt <= cnt + 1'b1;
        end
        NORM: begin
          F           <= special ? spec_f : norm_f;
          div_by_zero <= special && spec_dbz;
        end
        // out_valid is registered, so it rises one cycle after HOLD is entered.
        HOLD: out_valid <= !(out_valid && out_ready);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pes_pipedivider.sv
// Self-checking bench for pes_pipedivider: directed plan cases, back-pressure, reset mid-divide, random operands.
module tb_pes_pipedivider;
  localparam int QBITS = 26;
  localparam int BIAS  = 127;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, div_by_zero;
  logic [31:0] A, B, F;
  int          errors = 0;
  int          checks = 0;

  pes_pipedivider #(.QBITS(QBITS), .BIAS(BIAS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready), .F(F), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Exact quotient from integer division of the full significands.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] f, output logic dbz, output logic spc);
    int ea, eb, e;
    logic s, za, zb, ia, ib, na, nb, guard, sticky;
    longint unsigned num, den, qq, r, frac;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0); ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0); nb = (eb == 255) && (b[22:0] != 0);
    dbz = 1'b0; spc = 1'b1; f = {s, 31'h0};
    guard = 1'b0; sticky = 1'b0;
    if (na || nb) f = 32'h7FC00000;
    else if ((za && zb) || (ia && ib)) f = 32'h7FC00000;
    else if (ia) f = {s, 8'hFF, 23'h0};
    else if (ib) f = {s, 31'h0};
    else if (za) f = {s, 31'h0};
    else if (zb) begin f = {s, 8'hFF, 23'h0}; dbz = 1'b1; end
    else begin
      spc = 1'b0;
      num = longint'({1'b1, a[22:0]}) << (QBITS-1);
      den = longint'({1'b1, b[22:0]});
      e   = ea - eb + BIAS;
      if (num / den < (64'd1 << (QBITS-1))) begin num = num << 1; e--; end
      qq   = num / den;
      r    = num % den;
      frac = (qq >> (QBITS-24)) & 64'h7FFFFF;
`ifdef PES_PIPEDIVIDER_ROUND_EN
      guard  = ((qq >> (QBITS-25)) & 64'd1) != 0;
      sticky = ((qq & ((64'd1 << (QBITS-25)) - 1)) != 0) || (r != 0);
      if (guard && (sticky || frac[0])) frac++;
      if (frac == 64'h800000) begin frac = 0; e++; end
`endif
      if (e >= 255)    f = {s, 8'hFF, 23'h0};
      else if (e <= 0) f = {s, 31'h0};
      else             f = {s, 8'(e), 23'(frac)};
    end
  endfunction

  task automatic accept(input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    A = a; B = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    check("accept_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic release_result();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("post_hs_in_ready", {31'h0, in_ready}, 32'h1);
    check("post_hs_out_valid", {31'h0, out_valid}, 32'h0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] ef; logic edbz, spc; int lat;
    model(a, b, ef, edbz, spc);
    accept(a, b);
    wait_valid(lat);
    check({tag, "_lat"}, 32'(lat), spc ? 32'd2 : 32'(QBITS+2));
    check({tag, "_F"}, F, ef);
    check({tag, "_dbz"}, {31'h0, div_by_zero}, {31'h0, edbz});
    release_result();
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int unsigned cat;
    v   = $urandom;
    cat = $urandom_range(0, 11);
    case (cat)
      0: v[30:23] = 8'h00;
      1: begin v[30:23] = 8'hFF; v[22:0] = 23'h0; end
      2: v[30:23] = 8'hFF;
      3: v[30:23] = 8'(($urandom_range(0, 1) == 0) ? $urandom_range(1, 10) : $urandom_range(245, 254));
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] ef, f_hold; logic edbz, spc; int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_F", F, 32'h0);
    check("rst_dbz", {31'h0, div_by_zero}, 32'h0);

    run_op(32'h40C00000, 32'h40000000, "six_div_two");
    check("six_div_two_const", F, 32'h40400000);
    run_op(32'h3F800000, 32'h40400000, "one_third");
`ifdef PES_PIPEDIVIDER_ROUND_EN
    check("one_third_const", F, 32'h3EAAAAAB);
`else
    check("one_third_const", F, 32'h3EAAAAAA);
`endif
    run_op(32'hC1000000, 32'h40000000, "neg8_div2");
    check("neg8_div2_const", F, 32'hC0800000);
    run_op(32'h3F800000, 32'h00000000, "one_div_zero");
    check("one_div_zero_const", F, 32'h7F800000);
    run_op(32'h00000000, 32'h00000000, "zero_div_zero");
    check("zero_div_zero_const", F, 32'h7FC00000);
    run_op(32'h7F000000, 32'h3E800000, "overflow");
    check("overflow_const", F, 32'h7F800000);
    run_op(32'h00800000, 32'h4B000000, "underflow");
    check("underflow_const", F, 32'h00000000);
    run_op(32'h7F800000, 32'hC0000000, "inf_div_x");
    run_op(32'h40000000, 32'hFF800000, "x_div_inf");
    run_op(32'h7FC00001, 32'h3F800000, "nan_in");
    run_op(32'h00400000, 32'h3F800000, "subnormal_a");

    // Back-pressure: result must hold while a new pair waits on in_valid.
    model(32'h40C00000, 32'h40000000, ef, edbz, spc);
    accept(32'h40C00000, 32'h40000000);
    wait_valid(lat);
    check("bp_lat", 32'(lat), 32'(QBITS+2));
    f_hold = F;
    check("bp_F", f_hold, ef);
    @(negedge clk);
    A = 32'h41200000; B = 32'h40A00000; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_F", F, ef);
      check("bp_hold_valid", {31'h0, out_valid}, 32'h1);
      check("bp_hold_in_ready", {31'h0, in_ready}, 32'h0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("bp_rel_in_ready", {31'h0, in_ready}, 32'h1);
    check("bp_rel_out_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #1; in_valid = 1'b0;
    model(32'h41200000, 32'h40A00000, ef, edbz, spc);
    wait_valid(lat);
    check("bp_next_lat", 32'(lat), 32'(QBITS+2));
    check("bp_next_F", F, ef);
    check("bp_next_const", F, 32'h40000000);
    release_result();

    // Reset in the middle of a division discards the operation.
    accept(32'h3F800000, 32'h40400000);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst_in_ready", {31'h0, in_ready}, 32'h1);
    check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    check("midrst_F", F, 32'h0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 29) check("midrst_no_result", {31'h0, out_valid}, 32'h0);
    end
    run_op(32'h40C00000, 32'h40000000, "after_rst");

    for (int i = 0; i < 40; i++) run_op(rand_fp(), rand_fp(), "rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
